// File: rtl/yacht_score_ctrl.sv
// Yacht scorecard controller: sequences the shared score calculator, enforces one use per
// category per player, tracks totals with upper bonus. Optional sweep: YACHT_PREVIEW_EN.
module yacht_score_ctrl #(
    parameter int NUM_PLAYERS  = 2,
    parameter int BONUS_THRESH = 63,
    parameter int BONUS_PTS    = 35
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dice_valid,
    input  logic        cat_req,
    input  logic [3:0]  cat_idx,
    output logic [3:0]  calc_sel,
    input  logic [7:0]  calc_score,
    output logic        commit_done,
    output logic [7:0]  commit_score,
    output logic        reject,
    output logic [1:0]  cur_player,
    output logic [11:0] used_mask,
    input  logic [1:0]  rd_player,
    output logic [9:0]  rd_total,
    output logic        busy,
    output logic        game_over
`ifdef YACHT_PREVIEW_EN
    ,
    output logic        preview_valid,
    output logic [3:0]  preview_cat,
    output logic [7:0]  preview_score
`endif
);

    typedef enum logic [2:0] {
        IDLE_DICE,
`ifdef YACHT_PREVIEW_EN
        PREVIEW,
`endif
        AWAIT_CAT,
        COMMIT,
        DONE
    } state_t;

    state_t      state;
    logic [3:0]  round;
    logic [11:0] used  [4];
    logic [6:0]  upper [4];
    logic [9:0]  total [4];
    logic [3:0]  bonus;

    logic [11:0] used_cur;
    logic        req_ok;
    logic [6:0]  upper_next;
    logic        earn_bonus;
    logic [7:0]  bonus_add;
    logic        last_player;

    // NOTE: every variable gets a value on every path through always_comb, so no latch is inferred.
    always_comb begin
        used_cur    = used[cur_player];
        req_ok      = (state == AWAIT_CAT) && (cat_idx <= 4'd11) &&
                      ((used_cur & (12'd1 << cat_idx)) == 12'd0);
        upper_next  = upper[cur_player] + calc_score[6:0];
        earn_bonus  = (calc_sel <= 4'd5) && !bonus[cur_player] &&
                      (upper_next >= 7'(BONUS_THRESH));
        bonus_add   = earn_bonus ? 8'(BONUS_PTS) : 8'd0;
        last_player = (cur_player == 2'(NUM_PLAYERS - 1));
    end

    assign used_mask = used_cur;
    assign rd_total  = total[rd_player];
    assign busy      = (state != IDLE_DICE) && (state != DONE);
    assign game_over = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE_DICE;
            round        <= 4'd0;
            calc_sel     <= 4'd0;
            commit_done  <= 1'b0;
            commit_score <= 8'd0;
            reject       <= 1'b0;
            cur_player   <= 2'd0;
            bonus        <= 4'd0;
`ifdef YACHT_PREVIEW_EN
            preview_valid <= 1'b0;
            preview_cat   <= 4'd0;
            preview_score <= 8'd0;
`endif
            // NOTE: the per-player arrays are game state, not scratch storage, so reset must clear them.
            for (int p = 0; p < 4; p++) begin
                used[p]  <= 12'd0;
                upper[p] <= 7'd0;
                total[p] <= 10'd0;
            end
        end else begin
            commit_done <= 1'b0;
            // Any request not accepted in AWAIT_CAT is refused one cycle later.
            reject      <= cat_req && !req_ok;
`ifdef YACHT_PREVIEW_EN
            preview_valid <= 1'b0;
`endif
            case (state)
                IDLE_DICE: begin
                    if (dice_valid) begin
`ifdef YACHT_PREVIEW_EN
                        state    <= PREVIEW;
                        calc_sel <= 4'd0;
`else
                        state    <= AWAIT_CAT;
`endif
                    end
                end
`ifdef YACHT_PREVIEW_EN
                PREVIEW: begin
                    preview_valid <= (used_cur & (12'd1 << calc_sel)) == 12'd0;
                    preview_cat   <= calc_sel;
                    preview_score <= calc_score;
                    if (calc_sel == 4'd11) state <= AWAIT_CAT;
                    else                   calc_sel <= calc_sel + 4'd1;
                end
`endif
                AWAIT_CAT: begin
                    if (req_ok) begin
                        calc_sel <= cat_idx;
                        state    <= COMMIT;
                    end
                end
                COMMIT: begin
                    used[cur_player]  <= used_cur | (12'd1 << calc_sel);
                    total[cur_player] <= total[cur_player] + 10'(calc_score) + 10'(bonus_add);
                    if (calc_sel <= 4'd5) upper[cur_player] <= upper_next;
                    if (earn_bonus)       bonus[cur_player] <= 1'b1;
                    commit_done  <= 1'b1;
                    commit_score <= calc_score + bonus_add;
                    if (last_player) begin
                        cur_player <= 2'd0;
                        if (round == 4'd11) begin
                            state <= DONE;
                        end else begin
                            round <= round + 4'd1;
                            state <= IDLE_DICE;
                        end
                    end else begin
                        cur_player <= cur_player + 2'd1;
                        state      <= IDLE_DICE;
                    end
                end
                DONE: ;
                default: state <= IDLE_DICE;
            endcase
        end
    end

endmodule

// File: tb/tb_yacht_score_ctrl.sv
// Scoreboard bench for yacht_score_ctrl (default build, 2 players): expected commit/reject
// events are queued at stimulus time and popped by a monitor on the falling edge.
module tb_yacht_score_ctrl;

    typedef struct {
        logic       is_reject;
        logic [7:0] score;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dice_valid = 1'b0;
    logic        cat_req = 1'b0;
    logic [3:0]  cat_idx = 4'd0;
    logic [3:0]  calc_sel;
    logic [7:0]  calc_score;
    logic        commit_done;
    logic [7:0]  commit_score;
    logic        reject;
    logic [1:0]  cur_player;
    logic [11:0] used_mask;
    logic [1:0]  rd_player = 2'd0;
    logic [9:0]  rd_total;
    logic        busy;
    logic        game_over;

    logic [7:0]  tbl [16];
    exp_t        exp_q [$];
    int          checks = 0;
    int          errors = 0;

    // Hand-computed per-category scores for the full game; P0 earns the bonus on its fifth commit.
    logic [7:0] p0_sc  [12] = '{8'd15, 8'd12, 8'd9, 8'd12, 8'd15, 8'd18, 8'd20, 8'd0, 8'd25, 8'd30, 8'd40, 8'd50};
    logic [7:0] p0_exp [12] = '{8'd15, 8'd12, 8'd9, 8'd12, 8'd50, 8'd18, 8'd20, 8'd0, 8'd25, 8'd30, 8'd40, 8'd50};
    logic [7:0] p1_sc  [12] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd10, 8'd12, 8'd0, 8'd30, 8'd0, 8'd24};

    yacht_score_ctrl dut (
        .clk(clk), .rst(rst), .dice_valid(dice_valid), .cat_req(cat_req), .cat_idx(cat_idx),
        .calc_sel(calc_sel), .calc_score(calc_score), .commit_done(commit_done),
        .commit_score(commit_score), .reject(reject), .cur_player(cur_player),
        .used_mask(used_mask), .rd_player(rd_player), .rd_total(rd_total),
        .busy(busy), .game_over(game_over)
    );

    always #5 clk = ~clk;

    // Stand-in for the combinational score calculator.
    always_comb calc_score = tbl[calc_sel];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_total(input logic [1:0] p, input logic [9:0] req);
        rd_player = p;
        #1;
        check($sformatf("rd_total p%0d", p), 32'(rd_total), 32'(req));
    endtask

    function automatic void push(input logic is_rej, input logic [7:0] sc);
        exp_t e;
        e.is_reject = is_rej;
        e.score     = sc;
        exp_q.push_back(e);
    endfunction

    // Monitor: pops one expectation per observed commit_done and per observed reject.
    always @(negedge clk) begin
        exp_t e;
        if (commit_done) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected commit_done: score %0d", commit_score);
            end else begin
                e = exp_q.pop_front();
                check("event kind (commit)", 32'(e.is_reject), 32'(1'b0));
                check("commit_score", 32'(commit_score), 32'(e.score));
            end
        end
        if (reject) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected reject: got 1 expected 0");
            end else begin
                e = exp_q.pop_front();
                check("event kind (reject)", 32'(e.is_reject), 32'(1'b1));
            end
        end
    end

    // One turn: dice final, accepted request, commit; returns at the commit_done cycle.
    task automatic do_turn(input logic [3:0] cat, input logic [7:0] sc, input logic [7:0] exp_sc);
        tbl[cat]   = sc;
        dice_valid = 1'b1;
        step();
        dice_valid = 1'b0;
        cat_req    = 1'b1;
        cat_idx    = cat;
        push(1'b0, exp_sc);
        step();
        cat_req = 1'b0;
        check("calc_sel in COMMIT", 32'(calc_sel), 32'(cat));
        check("busy in COMMIT", 32'(busy), 32'd1);
        step();
    endtask

    task automatic refused_req(input logic [3:0] cat);
        cat_req = 1'b1;
        cat_idx = cat;
        push(1'b1, 8'd0);
        step();
        cat_req = 1'b0;
        step();
    endtask

    initial begin
        for (int i = 0; i < 16; i++) tbl[i] = 8'd0;

        // Reset state
        repeat (3) step();
        rst = 1'b0;
        check("rst calc_sel", 32'(calc_sel), 32'd0);
        check("rst commit_done", 32'(commit_done), 32'd0);
        check("rst commit_score", 32'(commit_score), 32'd0);
        check("rst reject", 32'(reject), 32'd0);
        check("rst cur_player", 32'(cur_player), 32'd0);
        check("rst used_mask", 32'(used_mask), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst game_over", 32'(game_over), 32'd0);
        check_total(2'd0, 10'd0);
        check_total(2'd1, 10'd0);
        step();

        // cat_req in IDLE_DICE is refused
        refused_req(4'd0);
        check("busy idle", 32'(busy), 32'd0);

        // Round 0: P0 full house (3,3,3,5,5) = 25
        do_turn(4'd8, 8'd25, 8'd25);
        check("cur_player after P0", 32'(cur_player), 32'd1);
        check("used_mask P1 empty", 32'(used_mask), 32'd0);
        check_total(2'd0, 10'd25);

        // P1: dice_valid and cat_req together -> dice taken, request refused
        tbl[0]     = 8'd7;
        dice_valid = 1'b1;
        cat_req    = 1'b1;
        cat_idx    = 4'd0;
        push(1'b1, 8'd0);
        step();
        dice_valid = 1'b0;
        cat_req    = 1'b1;
        push(1'b0, 8'd7);
        step();
        cat_req = 1'b0;
        check("calc_sel P1 cat0", 32'(calc_sel), 32'd0);
        step();
        check_total(2'd1, 10'd7);
        check("used_mask P0 bit8", 32'(used_mask), 32'h100);

        // Round 1 P0: reuse of cat 8 and cat 13 refused, then a legal commit
        dice_valid = 1'b1;
        step();
        dice_valid = 1'b0;
        refused_req(4'd8);
        check("busy awaiting", 32'(busy), 32'd1);
        check_total(2'd0, 10'd25);
        refused_req(4'd13);
        tbl[1]  = 8'd4;
        cat_req = 1'b1;
        cat_idx = 4'd1;
        push(1'b0, 8'd4);
        step();
        // request during COMMIT: refused in the same cycle commit_done rises
        cat_idx = 4'd2;
        push(1'b1, 8'd0);
        step();
        cat_req = 1'b0;
        check_total(2'd0, 10'd29);
        do_turn(4'd1, 8'd2, 8'd2);

        // Reset asserted during COMMIT
        tbl[2]     = 8'd9;
        dice_valid = 1'b1;
        step();
        dice_valid = 1'b0;
        cat_req    = 1'b1;
        cat_idx    = 4'd2;
        step();
        cat_req = 1'b0;
        rst     = 1'b1;
        step();
        check("mid reset commit_done", 32'(commit_done), 32'd0);
        check("mid reset cur_player", 32'(cur_player), 32'd0);
        check("mid reset used_mask", 32'(used_mask), 32'd0);
        check_total(2'd0, 10'd0);
        check_total(2'd1, 10'd0);
        rst = 1'b0;
        step();

        // Full 2-player game, 24 commits
        for (int r = 0; r < 12; r++) begin
            do_turn(4'(r), p0_sc[r], p0_exp[r]);
            if (r == 4) check_total(2'd0, 10'd98);
            if (r == 5) check_total(2'd0, 10'd116);
            do_turn(4'(r), p1_sc[r], p1_sc[r]);
            if (r < 11) check("game_over mid game", 32'(game_over), 32'd0);
        end
        check("game_over at end", 32'(game_over), 32'd1);
        check("busy at end", 32'(busy), 32'd0);
        check("used_mask P0 full", 32'(used_mask), 32'hFFF);
        check_total(2'd0, 10'd281);
        check_total(2'd1, 10'd97);

        // DONE is absorbing
        dice_valid = 1'b1;
        step();
        dice_valid = 1'b0;
        check("busy after dice in DONE", 32'(busy), 32'd0);
        refused_req(4'd3);
        check("game_over stays", 32'(game_over), 32'd1);
        step();
        check("scoreboard drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/yacht_score_ctrl.md
# yacht_score_ctrl

- Per-turn scorecard controller that sequences the shared combinational score calculator for every player.
- Waits for final dice, then drives the calculator's category select and enforces one use per category per player.
- Latches committed scores into per-player totals, including the upper-section bonus, and rotates turns until all 12 rounds are complete.
- Sits between the roll/hold FSM (dice source), the category-select UI and the display.

## Interface
- NUM_PLAYERS, 2, players in rotation (1..4)
- BONUS_THRESH, 63, upper subtotal (cats 0-5) that earns the bonus
- BONUS_PTS, 35, bonus added once per player
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- dice_valid  in  1  pulse: current dice are final for this turn
- cat_req  in  1  pulse: player requests category commit
- cat_idx  in  4  requested category 0-11
- calc_sel  out  4  registered drive to calculator category select
- calc_score  in  8  calculator score for calc_sel, valid same cycle
- commit_done  out  1  one-cycle pulse: score recorded
- commit_score  out  8  score recorded, incl. any bonus just earned
- reject  out  1  one-cycle pulse: cat_req refused
- cur_player  out  2  player whose turn it is
- used_mask  out  12  categories already used by cur_player
- rd_player  in  2  total readback select
- rd_total  out  10  total of rd_player, combinational read
- busy  out  1  high in any state except IDLE_DICE and DONE
- game_over  out  1  high in DONE until reset

## Operation
- States: IDLE_DICE, PREVIEW (only with macro), AWAIT_CAT, COMMIT, DONE.
- IDLE_DICE:
  - On dice_valid, go to PREVIEW if compiled in, else to AWAIT_CAT.
  - A cat_req here gives reject.
- AWAIT_CAT, cat_req with cat_idx <= 11 and unused bit:
  - calc_sel <= cat_idx.
  - Go to COMMIT.
- AWAIT_CAT, cat_req with cat_idx >= 12 or used:
  - reject pulses the next cycle.
  - Stay in AWAIT_CAT.
- COMMIT, sample calc_score:
  - Set the used bit and add calc_score to the total.
  - If cat <= 5, add it to the upper subtotal.
  - If the subtotal first reaches >= BONUS_THRESH, also add BONUS_PTS and set the player's bonus flag.
- COMMIT, after recording:
  - commit_done and commit_score are registered and valid the cycle after COMMIT.
  - Advance cur_player modulo NUM_PLAYERS.
  - On wrap, increment round (0..11).
  - After the last player's commit in round 11, go to DONE; else go to IDLE_DICE.
- DONE:
  - Absorbing state.
  - dice_valid is ignored; cat_req gives reject.
- Any cat_req arriving in PREVIEW or COMMIT gives reject.
- dice_valid outside IDLE_DICE is ignored.
- If dice_valid and cat_req arrive in the same cycle in IDLE_DICE: dice_valid is taken and cat_req is rejected.
- Widths:
  - Upper subtotal is 7 bits (max 105).
  - Total is 10 bits (max 345); no saturation is needed.
  - commit_score = calc_score + bonus; 8 bits, max 30 + 35.
- Reset mid-turn clears all state: scores, masks, round, player and bonus flags.

## Timing
- Reset values:
  - calc_sel 0, commit_done 0, commit_score 0, reject 0.
  - cur_player 0, used_mask 0, busy 0, game_over 0.
  - All totals 0; state IDLE_DICE.
- cat_req sampled at edge N (accepted): COMMIT during N..N+1.
- Score written at edge N+1; commit_done high during N+1..N+2.
- cur_player and used_mask update at edge N+1.
- reject follows a refused cat_req by exactly one cycle.
- Back-to-back turns:
  - dice_valid is accepted the cycle commit_done is high.
  - IDLE_DICE is entered at N+1.

## Configuration
- YACHT_PREVIEW_EN defined:
  - PREVIEW sweeps calc_sel 0..11 on 12 consecutive cycles.
  - Registered preview_valid / preview_cat[3:0] / preview_score[7:0] outputs lag calc_sel by one cycle.
  - preview_valid is high only for categories unused by cur_player.
  - After cat 11, go to AWAIT_CAT, so the first cat_req is accepted 13 cycles after dice_valid.
  - PREVIEW counts as busy.
- Undefined:
  - No PREVIEW state and no preview ports.
  - dice_valid goes directly to AWAIT_CAT the next cycle.

## Test plan
- Reset, dice 3,3,3,5,5, cat_req cat 8 -> calc_sel=8 in COMMIT, commit_done one cycle later with commit_score=25, used_mask bit8=1 for player 0, cur_player=1.
- Player 0 requests cat 8 again in a later round -> reject pulse, state stays AWAIT_CAT, total unchanged; cat_idx=13 -> reject.
- Player 0 commits upper scores 15,12,9,12,15 (63 after five commits) -> fifth commit_score=15+35=50, rd_total=98, bonus not added again on cat 5.
- Full 2-player game, 24 commits -> game_over high after the 24th commit_done, busy 0, later dice_valid/cat_req ignored/rejected.
- With YACHT_PREVIEW_EN: dice 1,2,3,4,5, cats 9 and 10 used -> 10 preview beats; beat for cat 6 has score 15; cat_req during the sweep is rejected.
- Reset asserted during COMMIT -> next cycle all totals 0, cur_player 0, no commit_done.
